// File: rtl/irom_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : irom_loader_pkg
//  Purpose  : Shared definitions for the instruction-memory program loader:
//             FSM state encodings, frame sync byte and word-count limit.
//  Ports    : (package, none)
//  Revision : 1.0  initial release
// ============================================================================
package irom_loader_pkg;

    // One state per frame field.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ADDR_H = 3'd1,
        S_ADDR_L = 3'd2,
        S_CNT_H  = 3'd3,
        S_CNT_L  = 3'd4,
        S_DATA_H = 3'd5,
        S_DATA_L = 3'd6,
        S_CSUM   = 3'd7
    } state_t;

    localparam logic [7:0] c_SYNC        = 8'hA5;
    localparam int         c_DWIDTH_DEF  = 16;
    localparam int         c_AWIDTH_DEF  = 12;

    // Largest legal word count: the whole memory, 2^aw words.
    // 17 bits so a 16-bit address space still fits.
    function automatic logic [16:0] max_count(input int aw);
        return 17'd1 << aw;
    endfunction

endpackage : irom_loader_pkg
`default_nettype wire

// File: rtl/irom_loader_if.sv
`default_nettype none
// ============================================================================
//  Module   : irom_loader_if
//  Purpose  : Bundles the loader's byte-input handshake, instruction-memory
//             write port and CPU/status outputs.
//  Ports    : rx_valid/rx_data/rx_ready  host byte stream
//             mem_we/mem_addr/mem_wdata   IROM write port
//             cpu_en/busy/done/err        CPU enable and load status
//  Modports : master - the loader (drives memory port and status)
//             slave  - host, IROM and CPU side
//  Revision : 1.0  initial release
// ============================================================================
interface irom_loader_if #(
    parameter int DWIDTH = 16,
    parameter int AWIDTH = 12
);
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rx_ready;
    logic              mem_we;
    logic [AWIDTH-1:0] mem_addr;
    logic [DWIDTH-1:0] mem_wdata;
    logic              cpu_en;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        input  rx_valid, rx_data,
        output rx_ready, mem_we, mem_addr, mem_wdata, cpu_en, busy, done, err
    );

    modport slave (
        output rx_valid, rx_data,
        input  rx_ready, mem_we, mem_addr, mem_wdata, cpu_en, busy, done, err
    );
endinterface : irom_loader_if
`default_nettype wire

// File: rtl/irom_loader.sv
`default_nettype none
// ============================================================================
//  Module   : irom_loader
//  Purpose  : Parses a framed byte stream
//               SYNC, ADDR_H, ADDR_L, CNT_H, CNT_L, {hi,lo} x CNT, CSUM
//             and writes the 16-bit words into the instruction memory.
//             Holds the CPU stopped while loading and releases it only after
//             the XOR checksum of the frame body matches.
//  Ports    : clk    system clock, rising edge
//             rst_n  synchronous active-low reset
//             bus    irom_loader_if.master (byte input, IROM write, status)
//  Revision : 1.0  initial release
// ============================================================================
import irom_loader_pkg::*;

module irom_loader #(
    parameter int         DWIDTH = c_DWIDTH_DEF,
    parameter int         AWIDTH = c_AWIDTH_DEF,
    parameter logic [7:0] SYNC   = c_SYNC
) (
    input  logic          clk,
    input  logic          rst_n,
    irom_loader_if.master bus
);

    localparam logic [16:0] c_MAX_CNT = max_count(AWIDTH);

    state_t            r_state,     w_state_nxt;
    logic [7:0]        r_hi,        w_hi_nxt;      // ADDR_H / CNT_H / DATA_H holding byte
    logic [7:0]        r_csum,      w_csum_nxt;
    logic [16:0]       r_remain,    w_remain_nxt;  // words still to receive
    logic [AWIDTH-1:0] r_ptr,       w_ptr_nxt;     // next write address
    logic              r_mem_we,    w_mem_we_nxt;
    logic [AWIDTH-1:0] r_mem_addr,  w_mem_addr_nxt;
    logic [DWIDTH-1:0] r_mem_wdata, w_mem_wdata_nxt;
    logic              r_cpu_en,    w_cpu_en_nxt;
    logic              r_done,      w_done_nxt;
    logic              r_err,       w_err_nxt;

    // The loader never back-pressures, so every valid byte is taken.
    logic        w_take;
    logic [15:0] w_pair;   // {held byte, current byte}
    logic [16:0] w_cnt;

    assign w_take = bus.rx_valid;
    assign w_pair = {r_hi, bus.rx_data};
    assign w_cnt  = {1'b0, w_pair};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_hi        <= 8'd0;
            r_csum      <= 8'd0;
            r_remain    <= 17'd0;
            r_ptr       <= '0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_cpu_en    <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_hi        <= w_hi_nxt;
            r_csum      <= w_csum_nxt;
            r_remain    <= w_remain_nxt;
            r_ptr       <= w_ptr_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_cpu_en    <= w_cpu_en_nxt;
            r_done      <= w_done_nxt;
            r_err       <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_hi_nxt        = r_hi;
        w_csum_nxt      = r_csum;
        w_remain_nxt    = r_remain;
        w_ptr_nxt       = r_ptr;
        w_mem_we_nxt    = 1'b0;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_cpu_en_nxt    = r_cpu_en;
        w_done_nxt      = 1'b0;
        w_err_nxt       = r_err;

        if (w_take) begin
            case (r_state)
                S_IDLE: begin
                    // Only SYNC starts a frame; anything else is line noise.
                    if (bus.rx_data == SYNC) begin
                        w_state_nxt  = S_ADDR_H;
                        w_csum_nxt   = 8'd0;
                        w_err_nxt    = 1'b0;
                        w_cpu_en_nxt = 1'b0;
                    end
                end
                S_ADDR_H: begin
                    w_hi_nxt    = bus.rx_data;
                    w_csum_nxt  = r_csum ^ bus.rx_data;
                    w_state_nxt = S_ADDR_L;
                end
                S_ADDR_L: begin
                    w_ptr_nxt   = w_pair[AWIDTH-1:0];
                    w_csum_nxt  = r_csum ^ bus.rx_data;
                    w_state_nxt = S_CNT_H;
                end
                S_CNT_H: begin
                    w_hi_nxt    = bus.rx_data;
                    w_csum_nxt  = r_csum ^ bus.rx_data;
                    w_state_nxt = S_CNT_L;
                end
                S_CNT_L: begin
                    w_csum_nxt = r_csum ^ bus.rx_data;
                    if (w_cnt == 17'd0) begin
                        w_state_nxt = S_CSUM;
                    end else if (w_cnt > c_MAX_CNT) begin
                        // More words than the memory holds: reject the frame.
                        w_err_nxt   = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_remain_nxt = w_cnt;
                        w_state_nxt  = S_DATA_H;
                    end
                end
                S_DATA_H: begin
                    w_hi_nxt    = bus.rx_data;
                    w_csum_nxt  = r_csum ^ bus.rx_data;
                    w_state_nxt = S_DATA_L;
                end
                S_DATA_L: begin
                    w_csum_nxt      = r_csum ^ bus.rx_data;
                    w_mem_we_nxt    = 1'b1;
                    w_mem_addr_nxt  = r_ptr;
                    w_mem_wdata_nxt = DWIDTH'(w_pair);
                    w_ptr_nxt       = r_ptr + AWIDTH'(1);   // wraps at top of memory
                    w_remain_nxt    = r_remain - 17'd1;
                    w_state_nxt     = (r_remain == 17'd1) ? S_CSUM : S_DATA_H;
                end
                S_CSUM: begin
                    // Written words stay in memory either way; only the CPU
                    // release depends on the checksum.
                    if (bus.rx_data == r_csum) begin
                        w_done_nxt   = 1'b1;
                        w_cpu_en_nxt = 1'b1;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                    w_state_nxt = S_IDLE;
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    assign bus.rx_ready  = 1'b1;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.cpu_en    = r_cpu_en;
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.done      = r_done;
    assign bus.err       = r_err;

endmodule : irom_loader
`default_nettype wire

// File: tb/tb_irom_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_irom_loader
//  Purpose  : Self-checking bench for irom_loader. Each table row is one
//             clock: the inputs applied for that cycle and the outputs
//             expected just after the following rising edge.
//  Ports    : none
//  Revision : 1.0  initial release
// ============================================================================
module tb_irom_loader;

    logic clk;
    logic rst_n;

    irom_loader_if #(.DWIDTH(16), .AWIDTH(12)) bus ();

    irom_loader #(.DWIDTH(16), .AWIDTH(12), .SYNC(8'hA5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        vld;
        logic [7:0]  data;
        logic        we;
        logic [11:0] addr;
        logic [15:0] wdata;
        logic        chk_bus;   // check addr/wdata even without a write
        logic        done;
        logic        en;
        logic        err;
        logic        busy;
    } vec_t;

    vec_t vecs[$];
    int   n_total;
    int   n_pass;

    // Current expected sticky outputs while building the table.
    logic e_en;
    logic e_err;

    function automatic void push(logic r, logic v, logic [7:0] d, logic we,
                                 logic [11:0] a, logic [15:0] w, logic cb,
                                 logic dn, logic en, logic er, logic bs);
        vec_t x;
        x.rst_n = r; x.vld = v; x.data = d; x.we = we; x.addr = a;
        x.wdata = w; x.chk_bus = cb; x.done = dn; x.en = en; x.err = er;
        x.busy = bs;
        vecs.push_back(x);
    endfunction

    // Byte that leaves the frame in progress, no write.
    function automatic void by(logic [7:0] d);
        push(1'b1, 1'b1, d, 1'b0, 12'h0, 16'h0, 1'b0, 1'b0, e_en, e_err, 1'b1);
    endfunction
    // SYNC byte: drops cpu_en and clears err.
    function automatic void sy();
        e_en = 1'b0; e_err = 1'b0;
        by(8'hA5);
    endfunction
    // Idle gap inside or outside a frame.
    function automatic void gap(logic bs);
        push(1'b1, 1'b0, 8'h00, 1'b0, 12'h0, 16'h0, 1'b0, 1'b0, e_en, e_err, bs);
    endfunction
    // DATA_L byte producing a write.
    function automatic void wr(logic [7:0] d, logic [11:0] a, logic [15:0] w);
        push(1'b1, 1'b1, d, 1'b1, a, w, 1'b1, 1'b0, e_en, e_err, 1'b1);
    endfunction
    // Checksum byte, good or bad.
    function automatic void cs(logic [7:0] d, logic good);
        if (good) e_en = 1'b1; else e_err = 1'b1;
        push(1'b1, 1'b1, d, 1'b0, 12'h0, 16'h0, 1'b0, good, e_en, e_err, 1'b0);
    endfunction
    // Byte seen while idle (or ending the frame with a count error).
    function automatic void idle_by(logic [7:0] d);
        push(1'b1, 1'b1, d, 1'b0, 12'h0, 16'h0, 1'b0, 1'b0, e_en, e_err, 1'b0);
    endfunction
    // Reset cycle: everything zero afterwards, including addr/wdata.
    function automatic void rs(logic v, logic [7:0] d);
        e_en = 1'b0; e_err = 1'b0;
        push(1'b0, v, d, 1'b0, 12'h0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    endfunction

    function automatic void basic_frame(logic [7:0] csum, logic good);
        sy(); by(8'h00); by(8'h00); by(8'h00); by(8'h02);
        by(8'h12); wr(8'h34, 12'h000, 16'h1234);
        by(8'hAB); wr(8'hCD, 12'h001, 16'hABCD);
        cs(csum, good);
    endfunction

    task automatic chk(input string name, input int row,
                       input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
    endtask

    initial begin
        n_total = 0; n_pass = 0;
        e_en = 1'b0; e_err = 1'b0;
        rst_n = 1'b0; bus.rx_valid = 1'b0; bus.rx_data = 8'h00;

        // Reset state.
        rs(1'b0, 8'h00);
        // Basic load.
        basic_frame(8'h42, 1'b1);
        // Bad checksum: words still written, err set, no done.
        basic_frame(8'h43, 1'b0);
        // Good frame with stalls; also clears err.
        sy(); gap(1'b1); by(8'h00); gap(1'b1); by(8'h00); by(8'h00); gap(1'b1);
        by(8'h02); by(8'h12); gap(1'b1); wr(8'h34, 12'h000, 16'h1234); gap(1'b1);
        by(8'hAB); gap(1'b1); wr(8'hCD, 12'h001, 16'hABCD); gap(1'b1);
        cs(8'h42, 1'b1);
        gap(1'b0);
        // Address wrap 0xFFF -> 0x000.
        sy(); by(8'h0F); by(8'hFF); by(8'h00); by(8'h02);
        by(8'h11); wr(8'h11, 12'hFFF, 16'h1111);
        by(8'h22); wr(8'h22, 12'h000, 16'h2222);
        cs(8'hF2, 1'b1);
        // Reload with count zero: cpu_en drops on A5, no writes.
        sy(); by(8'h00); by(8'h10); by(8'h00); by(8'h00);
        cs(8'h10, 1'b1);
        // Reset clears a set cpu_en.
        rs(1'b0, 8'h00);
        // SYNC inside the frame is data.
        sy(); by(8'h00); by(8'h00); by(8'h00); by(8'h01);
        by(8'hA5); wr(8'hA5, 12'h000, 16'hA5A5);
        cs(8'h01, 1'b1);
        // Reset mid-frame right after a write.
        sy(); by(8'h00); by(8'h00); by(8'h00); by(8'h02);
        by(8'h12); wr(8'h34, 12'h000, 16'h1234);
        rs(1'b1, 8'hAB);
        // Back in IDLE: non-SYNC bytes ignored, then a full load works.
        idle_by(8'h12); idle_by(8'h00);
        basic_frame(8'h42, 1'b1);
        // Count 0x1000 is the largest legal count.
        sy(); by(8'h00); by(8'h00); by(8'h10); by(8'h00); by(8'h55);
        rs(1'b0, 8'h00);
        // Count 0x1001 is rejected without writes; following bytes ignored.
        sy(); by(8'h00); by(8'h00); by(8'h10);
        e_err = 1'b1; idle_by(8'h01);
        idle_by(8'h12); idle_by(8'h34); idle_by(8'h56);
        // Reset clears err.
        rs(1'b0, 8'h00);
        gap(1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst_n        = vecs[i].rst_n;
            bus.rx_valid = vecs[i].vld;
            bus.rx_data  = vecs[i].data;
            @(posedge clk);
            #1;
            chk("mem_we", i, 32'(bus.mem_we), 32'(vecs[i].we));
            chk("done",   i, 32'(bus.done),   32'(vecs[i].done));
            chk("cpu_en", i, 32'(bus.cpu_en), 32'(vecs[i].en));
            chk("err",    i, 32'(bus.err),    32'(vecs[i].err));
            chk("busy",   i, 32'(bus.busy),   32'(vecs[i].busy));
            if (vecs[i].rst_n)
                chk("rx_ready", i, 32'(bus.rx_ready), 32'd1);
            if (vecs[i].we || vecs[i].chk_bus) begin
                chk("mem_addr",  i, 32'(bus.mem_addr),  32'(vecs[i].addr));
                chk("mem_wdata", i, 32'(bus.mem_wdata), 32'(vecs[i].wdata));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_irom_loader
`default_nettype wire
